tile_scheduler: RTL and testbench
=================================

Name: tile_scheduler

Overview:
- Top-level sequencer for the tiled systolic-array matmul C = A x W.
  - A is ROW_M x COL_M.
  - W is ROW_N x COL_N, with COL_M == ROW_N.
- Walks the tile loops i (outer), j, k (inner) and drives the address generator's load_a/load_w/deload_out strobes and tile base indices.
- Also drives the array's accumulator clear and compute enable.
- One instance per array, between the host start/done interface and sys_addr_gen plus the PE grid.

Parameters:
ROW_M, 8, rows of A and C
COL_M, 8, columns of A = rows of W (K dimension)
COL_N, 8, columns of W and C
TILE, 4, systolic array edge; ROW_M, COL_M and COL_N must be multiples of TILE (otherwise elaboration error)
COMPUTE_CYCLES, 10, cycles compute_en stays high per k-tile (3*TILE-2 default)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  begin a matmul; sampled only in IDLE
abort  in  1  synchronous cancel; forces IDLE, no done pulse
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse after the final deload
load_a  out  1  A tile load strobe to address generator
load_w  out  1  W tile load strobe to address generator
deload_out  out  1  result drain strobe
acc_clr  out  1  one-cycle accumulator clear for the PE grid
compute_en  out  1  PE grid compute enable
index_i  out  $clog2(ROW_M)+1  row base of the current tile (element units, step TILE)
index_j  out  $clog2(COL_N)+1  column base of the current tile
index_k  out  $clog2(COL_M)+1  K base of the current tile

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; phase counter 0; indices 0.
- States: IDLE, LOAD, COMPUTE, DELOAD, DONE. Phase counter width is $clog2(max(TILE,COMPUTE_CYCLES))+1.
- IDLE: start=1 -> LOAD next cycle, with i=j=k=0. start=0 -> remain.
- LOAD: load_a=load_w=1 for exactly TILE cycles, then COMPUTE.
  - acc_clr=1 in the first LOAD cycle only, and only when index_k==0.
- COMPUTE: compute_en=1 for exactly COMPUTE_CYCLES cycles. Then:
  - if index_k+TILE < COL_M: index_k += TILE, go to LOAD;
  - else go to DELOAD.
- DELOAD: deload_out=1 for exactly TILE cycles; index_i and index_j hold. Then:
  - index_k=0;
  - if index_j+TILE < COL_N: index_j += TILE, go to LOAD;
  - else if index_i+TILE < ROW_M: index_j=0, index_i += TILE, go to LOAD;
  - else go to DONE.
- DONE: done=1 for one cycle, then IDLE. Indices reset to 0 on entry to IDLE.
- Index stability:
  - Indices change only on state-transition edges.
  - Indices are stable for every cycle in which any strobe is high.
- Strobe separation: load_a/load_w and deload_out are never high in the same cycle.
  - Each strobe is low for at least one cycle between assertions.
  - This guarantees the rising edge that the address generator uses to capture indices.
- Strobe timing: all strobes are registered outputs, asserted in the first cycle of their state.
- Per-(i,j) tile cost: Tk*(TILE+COMPUTE_CYCLES)+TILE cycles, where Tk = COL_M/TILE.
  - busy is high for Ti*Tj*(per-tile cost)+1 cycles (the +1 is DONE), where Ti = ROW_M/TILE and Tj = COL_N/TILE.
- start while busy: ignored, no effect on the sequence.
- abort=1 in any non-IDLE state: next state IDLE.
  - All strobes deasserted the following cycle.
  - Indices cleared; no done.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: abort wins, remain IDLE.
- Degenerate sizes:
  - COL_M==TILE: single LOAD/COMPUTE per tile.
  - ROW_M==COL_N==TILE: single output tile, DONE after first DELOAD.
- Reset mid-operation: immediate return to reset values, no done pulse.

Test Plan:
- Defaults (8/8/8, TILE=4, CC=10), start pulse -> LOAD at cycle 1; busy high 129 cycles; done at cycle 129.
  - (i,j) visit order: (0,0),(0,4),(4,0),(4,4); k sequence 0,4 per tile.
  - acc_clr exactly 4 pulses.
- Strobe widths: every load_a/load_w burst exactly 4 cycles; compute_en bursts 10 cycles; deload_out bursts 4 cycles.
  - Indices constant across each burst; load and deload never overlap.
- start re-pulsed at cycle 50 -> no change to sequence or done timing.
  - A second start after done restarts from (0,0,0).
- abort during second COMPUTE (cycle 20) -> busy low at cycle 21; all strobes 0; indices 0; no done pulse.
- reset asserted during DELOAD of tile (0,4) -> outputs 0 asynchronously.
  - After release plus start, the sequence restarts cleanly at (0,0).
- COL_M=4, ROW_M=COL_N=4, CC=10 -> LOAD 4, COMPUTE 10, DELOAD 4, done at cycle 19.

Source files
------------

// File: rtl/tile_scheduler_if.sv
// Host/array-side bundle for the tile scheduler: start/abort handshake in,
// load/compute/deload strobes and tile base indices out.
interface tile_scheduler_if #(
  parameter int IW = 4,
  parameter int JW = 4,
  parameter int KW = 4
);
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          load_a;
  logic          load_w;
  logic          deload_out;
  logic          acc_clr;
  logic          compute_en;
  logic [IW-1:0] index_i;
  logic [JW-1:0] index_j;
  logic [KW-1:0] index_k;

  // Scheduler side: consumes start/abort, drives everything else.
  modport master (
    input  start, abort,
    output busy, done, load_a, load_w, deload_out, acc_clr, compute_en,
    output index_i, index_j, index_k
  );

  // Host / address-generator / PE-grid side.
  modport slave (
    output start, abort,
    input  busy, done, load_a, load_w, deload_out, acc_clr, compute_en,
    input  index_i, index_j, index_k
  );
endinterface

// File: rtl/tile_scheduler.sv
// Tile-loop sequencer for C = A x W on a TILE x TILE systolic array.
// Walks i (outer), j, k (inner); per k-tile a LOAD burst then a COMPUTE
// burst, per (i,j) tile a final DELOAD burst, then a one-cycle DONE.
// Every output is a register written on the same edge as the state it
// belongs to, so strobes rise in the first cycle of their state.
module tile_scheduler #(
  parameter int ROW_M          = 8,
  parameter int COL_M          = 8,
  parameter int COL_N          = 8,
  parameter int TILE           = 4,
  parameter int COMPUTE_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  tile_scheduler_if.master bus
);
  localparam int IW   = $clog2(ROW_M) + 1;
  localparam int JW   = $clog2(COL_N) + 1;
  localparam int KW   = $clog2(COL_M) + 1;
  localparam int PMAX = (TILE > COMPUTE_CYCLES) ? TILE : COMPUTE_CYCLES;
  localparam int PW   = $clog2(PMAX) + 1;

  localparam logic [PW-1:0] TILE_LAST = PW'(TILE - 1);
  localparam logic [PW-1:0] CC_LAST   = PW'(COMPUTE_CYCLES - 1);
  localparam logic [IW-1:0] STEP_I    = IW'(TILE);
  localparam logic [JW-1:0] STEP_J    = JW'(TILE);
  localparam logic [KW-1:0] STEP_K    = KW'(TILE);

  // Matrix dimensions must tile exactly; refuse to elaborate otherwise.
  if ((TILE < 1) || (COMPUTE_CYCLES < 1) || ((ROW_M % TILE) != 0) ||
      ((COL_M % TILE) != 0) || ((COL_N % TILE) != 0)) begin : g_bad_cfg
    $error("tile_scheduler: ROW_M/COL_M/COL_N must be multiples of TILE");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DELOAD  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state_r;
  logic [PW-1:0] phase_r;
  logic          busy_r;
  logic          done_r;
  logic          load_r;
  logic          deload_r;
  logic          acc_clr_r;
  logic          compute_en_r;
  logic [IW-1:0] index_i_r;
  logic [JW-1:0] index_j_r;
  logic [KW-1:0] index_k_r;

  // Loop-termination tests done in plain integer arithmetic so the
  // "base + TILE" sum can never wrap in the narrow index registers.
  logic more_k_s;
  logic more_j_s;
  logic more_i_s;
  assign more_k_s = (int'(index_k_r) + TILE) < COL_M;
  assign more_j_s = (int'(index_j_r) + TILE) < COL_N;
  assign more_i_s = (int'(index_i_r) + TILE) < ROW_M;

  // Sequencer FSM: state, phase counter, indices and all registered strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      phase_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      load_r       <= 1'b0;
      deload_r     <= 1'b0;
      acc_clr_r    <= 1'b0;
      compute_en_r <= 1'b0;
      index_i_r    <= '0;
      index_j_r    <= '0;
      index_k_r    <= '0;
    end else if (bus.abort && (state_r != S_IDLE)) begin
      // Cancel: back to IDLE with everything cleared and no done pulse.
      state_r      <= S_IDLE;
      phase_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      load_r       <= 1'b0;
      deload_r     <= 1'b0;
      acc_clr_r    <= 1'b0;
      compute_en_r <= 1'b0;
      index_i_r    <= '0;
      index_j_r    <= '0;
      index_k_r    <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start && !bus.abort) begin
            state_r   <= S_LOAD;
            phase_r   <= '0;
            busy_r    <= 1'b1;
            load_r    <= 1'b1;
            acc_clr_r <= 1'b1;
            index_i_r <= '0;
            index_j_r <= '0;
            index_k_r <= '0;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_LOAD: begin
          acc_clr_r <= 1'b0;
          if (phase_r == TILE_LAST) begin
            state_r      <= S_COMPUTE;
            phase_r      <= '0;
            load_r       <= 1'b0;
            compute_en_r <= 1'b1;
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end
        S_COMPUTE: begin
          if (phase_r == CC_LAST) begin
            phase_r      <= '0;
            compute_en_r <= 1'b0;
            if (more_k_s) begin
              // Next K slice accumulates onto the same (i,j) tile: no clear.
              state_r   <= S_LOAD;
              load_r    <= 1'b1;
              index_k_r <= index_k_r + STEP_K;
            end else begin
              state_r  <= S_DELOAD;
              deload_r <= 1'b1;
            end
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end
        S_DELOAD: begin
          if (phase_r == TILE_LAST) begin
            phase_r   <= '0;
            deload_r  <= 1'b0;
            index_k_r <= '0;
            if (more_j_s) begin
              state_r   <= S_LOAD;
              load_r    <= 1'b1;
              acc_clr_r <= 1'b1;
              index_j_r <= index_j_r + STEP_J;
            end else if (more_i_s) begin
              state_r   <= S_LOAD;
              load_r    <= 1'b1;
              acc_clr_r <= 1'b1;
              index_j_r <= '0;
              index_i_r <= index_i_r + STEP_I;
            end else begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            phase_r <= phase_r + PW'(1);
          end
        end
        S_DONE: begin
          state_r   <= S_IDLE;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          index_i_r <= '0;
          index_j_r <= '0;
          index_k_r <= '0;
        end
        default: begin
          state_r      <= S_IDLE;
          phase_r      <= '0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          load_r       <= 1'b0;
          deload_r     <= 1'b0;
          acc_clr_r    <= 1'b0;
          compute_en_r <= 1'b0;
          index_i_r    <= '0;
          index_j_r    <= '0;
          index_k_r    <= '0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.load_a     = load_r;
  assign bus.load_w     = load_r;
  assign bus.deload_out = deload_r;
  assign bus.acc_clr    = acc_clr_r;
  assign bus.compute_en = compute_en_r;
  assign bus.index_i    = index_i_r;
  assign bus.index_j    = index_j_r;
  assign bus.index_k    = index_k_r;
endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: a default 8/8/8 instance and a degenerate 4/4/4
// instance. The expected per-cycle output trace is generated from nested
// i/j/k loops and compared cycle by cycle, with random start re-pulses,
// aborts and an asynchronous reset in the middle of a run.
module tb_tile_scheduler;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tile_scheduler_if #(.IW(4), .JW(4), .KW(4)) bus_big ();
  tile_scheduler_if #(.IW(3), .JW(3), .KW(3)) bus_sml ();

  tile_scheduler #(
    .ROW_M(8), .COL_M(8), .COL_N(8), .TILE(4), .COMPUTE_CYCLES(10)
  ) dut_big (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_big.master)
  );

  tile_scheduler #(
    .ROW_M(4), .COL_M(4), .COL_N(4), .TILE(4), .COMPUTE_CYCLES(10)
  ) dut_sml (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_sml.master)
  );

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Output vector layout: {0, busy, done, load_a, load_w, deload, acc_clr, compute_en, i, j, k}
  function automatic logic [31:0] pack(input logic b, input logic d, input logic la,
                                       input logic lw, input logic dl, input logic ac,
                                       input logic ce, input int i, input int j, input int k);
    return {1'b0, b, d, la, lw, dl, ac, ce, 8'(i), 8'(j), 8'(k)};
  endfunction

  function automatic logic [31:0] obs(input int sel);
    if (sel == 0)
      return pack(bus_big.busy, bus_big.done, bus_big.load_a, bus_big.load_w,
                  bus_big.deload_out, bus_big.acc_clr, bus_big.compute_en,
                  int'(bus_big.index_i), int'(bus_big.index_j), int'(bus_big.index_k));
    else
      return pack(bus_sml.busy, bus_sml.done, bus_sml.load_a, bus_sml.load_w,
                  bus_sml.deload_out, bus_sml.acc_clr, bus_sml.compute_en,
                  int'(bus_sml.index_i), int'(bus_sml.index_j), int'(bus_sml.index_k));
  endfunction

  task automatic set_inputs(input int sel, input logic st, input logic ab);
    if (sel == 0) begin
      bus_big.start = st;
      bus_big.abort = ab;
    end else begin
      bus_sml.start = st;
      bus_sml.abort = ab;
    end
  endtask

  // Reference trace built straight from the tiled loop nest.
  task automatic build_trace(input int rm, input int cm, input int cn, input int t, input int cc);
    exp_q.delete();
    for (int i = 0; i < rm; i += t) begin
      for (int j = 0; j < cn; j += t) begin
        for (int k = 0; k < cm; k += t) begin
          for (int p = 0; p < t; p++)
            exp_q.push_back(pack(1, 0, 1, 1, 0, (k == 0 && p == 0), 0, i, j, k));
          for (int p = 0; p < cc; p++)
            exp_q.push_back(pack(1, 0, 0, 0, 0, 0, 1, i, j, k));
        end
        for (int p = 0; p < t; p++)
          exp_q.push_back(pack(1, 0, 0, 0, 1, 0, 0, i, j, cm - t));
      end
    end
    exp_q.push_back(pack(1, 1, 0, 0, 0, 0, 0, rm - t, cn - t, 0));
  endtask

  // One matmul run on instance sel; optional abort cycle, reset cycle, random start noise.
  task automatic run_seq(input int sel, input string tag, input int abort_at,
                         input int reset_at, input bit rand_start);
    int rm, cm, cn, t, cc, exp_len, busy_cnt, done_at;
    logic [31:0] o, want;
    logic st, ab;
    if (sel == 0) begin rm = 8; cm = 8; cn = 8; t = 4; cc = 10; end
    else begin rm = 4; cm = 4; cn = 4; t = 4; cc = 10; end
    exp_len  = (rm / t) * (cn / t) * ((cm / t) * (t + cc) + t) + 1;
    build_trace(rm, cm, cn, t, cc);
    busy_cnt = 0;
    done_at  = -1;
    set_inputs(sel, 1'b0, 1'b0);
    repeat ($urandom_range(0, 3)) begin
      check({tag, "_pre_idle"}, obs(sel), 32'h0);
      @(negedge clk);
    end
    set_inputs(sel, 1'b1, 1'b0);
    @(negedge clk);
    for (int n = 0; n < exp_q.size(); n++) begin
      o    = obs(sel);
      want = (abort_at >= 0 && n + 1 > abort_at) ? 32'h0 : exp_q[n];
      check(tag, o, want);
      if (o[30]) busy_cnt++;
      if (o[29]) done_at = n + 1;
      if (reset_at == n + 1) begin
        set_inputs(sel, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check({tag, "_async_reset"}, obs(sel), 32'h0);
        @(negedge clk);
        check({tag, "_in_reset"}, obs(sel), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_after_release"}, obs(sel), 32'h0);
        return;
      end
      st = (abort_at < 0) && ((n + 1 == 50) || (rand_start && $urandom_range(0, 7) == 0));
      ab = (n + 1 == abort_at);
      set_inputs(sel, st, ab);
      @(negedge clk);
    end
    set_inputs(sel, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      check({tag, "_post_idle"}, obs(sel), 32'h0);
      @(negedge clk);
    end
    if (abort_at < 0) begin
      check({tag, "_busy_cycles"}, busy_cnt, exp_len);
      check({tag, "_done_cycle"}, done_at, exp_len);
    end else begin
      check({tag, "_no_done"}, done_at, -1);
    end
  endtask

  // Stimulus sequence and summary.
  initial begin
    reset = 1'b0;
    set_inputs(0, 1'b0, 1'b0);
    set_inputs(1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("reset_big", obs(0), 32'h0);
    check("reset_sml", obs(1), 32'h0);
    reset = 1'b1;
    @(negedge clk);

    run_seq(0, "seq_first", -1, -1, 1'b1);
    run_seq(0, "seq_restart", -1, -1, 1'b1);

    set_inputs(0, 1'b1, 1'b1);
    @(negedge clk);
    check("idle_abort_start", obs(0), 32'h0);
    set_inputs(0, 1'b0, 1'b1);
    @(negedge clk);
    check("idle_abort_only", obs(0), 32'h0);
    set_inputs(0, 1'b0, 1'b0);
    @(negedge clk);

    run_seq(0, "abort_c20", 20, -1, 1'b0);
    run_seq(0, "abort_rand", int'($urandom_range(1, 128)), -1, 1'b0);
    run_seq(0, "reset_deload", -1, 62, 1'b0);
    run_seq(0, "after_reset", -1, -1, 1'b1);
    run_seq(1, "small", -1, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
